// File: rtl/serial_xor_frame_checker.sv
// Serial XOR frame checker: counts a/b mismatches over FRAME_LEN pairs and holds the result.
// Optional registered equal flag when SERIAL_XOR_EQUAL_FLAG_EN is defined.
module serial_xor_frame_checker #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a,
    input  logic             b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] mismatch_count,
    output logic             parity,
`ifdef SERIAL_XOR_EQUAL_FLAG_EN
    output logic             equal,
`endif
    output logic [CNT_W-1:0] bit_idx
);

    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] LP_FULL = CNT_W'(FRAME_LEN);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_idx;
    logic             r_par;
    logic             w_n1;
    logic             w_n2;
    logic             w_n3;
    logic             w_d;
    logic [CNT_W-1:0] w_cnt_nxt;
`ifdef SERIAL_XOR_EQUAL_FLAG_EN
    logic             r_equal;
`endif

    // Four-gate NAND XOR
    assign w_n1 = ~(a & b);
    assign w_n2 = ~(a & w_n1);
    assign w_n3 = ~(b & w_n1);
    assign w_d  = ~(w_n2 & w_n3);

    assign w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, w_d};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= COLLECT;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_par   <= 1'b0;
`ifdef SERIAL_XOR_EQUAL_FLAG_EN
            r_equal <= 1'b0;
`endif
        end else begin
            case (r_state)
                COLLECT: begin
                    if (in_valid) begin
                        r_cnt <= w_cnt_nxt;
                        r_par <= r_par ^ w_d;
                        if (r_idx == LP_LAST) begin
                            r_state <= HOLD;
                            r_idx   <= LP_FULL;
`ifdef SERIAL_XOR_EQUAL_FLAG_EN
                            r_equal <= (w_cnt_nxt == '0);
`endif
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state <= COLLECT;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_par   <= 1'b0;
`ifdef SERIAL_XOR_EQUAL_FLAG_EN
                        r_equal <= 1'b0;
`endif
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

    assign in_ready       = (r_state == COLLECT);
    assign out_valid      = (r_state == HOLD);
    assign mismatch_count = r_cnt;
    assign parity         = r_par;
    assign bit_idx        = r_idx;
`ifdef SERIAL_XOR_EQUAL_FLAG_EN
    assign equal          = r_equal;
`endif

endmodule

// File: tb/tb_serial_xor_frame_checker.sv
// Directed bench for serial_xor_frame_checker (FRAME_LEN=8, CNT_W=4).
module tb_serial_xor_frame_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] mismatch_count;
    logic       parity;
    logic [3:0] bit_idx;
`ifdef SERIAL_XOR_EQUAL_FLAG_EN
    logic       equal;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_xor_frame_checker #(.FRAME_LEN(8), .CNT_W(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .a              (a),
        .b              (b),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .mismatch_count (mismatch_count),
        .parity         (parity),
`ifdef SERIAL_XOR_EQUAL_FLAG_EN
        .equal          (equal),
`endif
        .bit_idx        (bit_idx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".count"}, 32'(mismatch_count), 32'd0);
        chk({tag, ".parity"}, 32'(parity), 32'd0);
        chk({tag, ".bit_idx"}, 32'(bit_idx), 32'd0);
`ifdef SERIAL_XOR_EQUAL_FLAG_EN
        chk({tag, ".equal"}, 32'(equal), 32'd0);
`endif
    endtask

    task automatic chk_hold(input string tag, input int cnt, input logic par, input logic eq);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, ".count"}, 32'(mismatch_count), 32'(cnt));
        chk({tag, ".parity"}, 32'(parity), 32'(par));
        chk({tag, ".bit_idx"}, 32'(bit_idx), 32'd8);
`ifdef SERIAL_XOR_EQUAL_FLAG_EN
        chk({tag, ".equal"}, 32'(equal), 32'(eq));
`else
        if (eq) begin end
`endif
    endtask

    // Pairs are sent MSB first; gap inserts that many idle cycles after each pair.
    task automatic send_frame(input string tag, input logic [7:0] av, input logic [7:0] bv,
                              input int gap);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk({tag, ".idx_pre"}, 32'(bit_idx), 32'(i));
            chk({tag, ".ov_pre"}, 32'(out_valid), 32'd0);
            in_valid = 1'b1;
            a = av[7-i];
            b = bv[7-i];
            for (int g = 0; g < gap && i < 7; g++) begin
                @(negedge clk);
                in_valid = 1'b0;
                a = ~a;
                chk({tag, ".idx_gap"}, 32'(bit_idx), 32'(i + 1));
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic accept(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk_idle(tag);
    endtask

    initial begin
        // Async reset between edges, before any clock edge.
        #3 reset = 1'b1;
        #1 chk_idle("rst_async");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk_idle("out_ready_in_collect");

        send_frame("f_equal", 8'b10110010, 8'b10110010, 0);
        chk_hold("f_equal", 0, 1'b0, 1'b1);
        accept("acc1");

        send_frame("f_all", 8'b11110000, 8'b00001111, 0);
        chk_hold("f_all", 8, 1'b0, 1'b0);
        accept("acc2");

        send_frame("f_one", 8'b10000000, 8'b00000000, 0);
        chk_hold("f_one", 1, 1'b1, 1'b0);
        accept("acc3");

        // Gapped frame; pairs offered during HOLD must be ignored.
        send_frame("f_gap", 8'b11001100, 8'b01010101, 2);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            a = 1'b1;
            b = 1'b0;
            @(negedge clk);
            chk_hold("hold_stable", 4, 1'b0, 1'b0);
        end
        in_valid = 1'b0;
        accept("acc4");

        send_frame("f_b2b", 8'b11100000, 8'b00000000, 0);
        chk_hold("f_b2b", 3, 1'b1, 1'b0);
        accept("acc5");

        // Reset after 4 pairs discards the partial frame.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = 1'b1;
            b = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("partial.count", 32'(mismatch_count), 32'd4);
        chk("partial.idx", 32'(bit_idx), 32'd4);
        #2 reset = 1'b1;
        #1 chk_idle("rst_mid");
        @(negedge clk);
        reset = 1'b0;

        send_frame("f_after_rst", 8'b01010101, 8'b00000000, 0);
        chk_hold("f_after_rst", 4, 1'b0, 1'b0);
        accept("acc6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
